acc_sequencer: RTL

- Control and accumulator stage directly upstream of the 4-bit ALU in the accumulator datapath.
- Accepts one instruction per valid/ready handshake, holding an opcode and an immediate operand.
- Drives the ALU with A = accumulator and B = operand plus the matching 4-bit ctrl code, then writes the ALU result and flags back into the accumulator register.
- LOAD and NOP are handled locally, without using the ALU result.

---
 rtl/acc_pkg.sv | 27 ++
 rtl/acc_op_decode.sv | 33 +++
 rtl/acc_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared opcodes, ALU ctrl codes and FSM state encoding for the accumulator sequencer.
// Optional feature macro used by acc_sequencer: ACC_STICKY_OVR_EN.
package acc_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/acc_op_decode.sv
// Combinational opcode decode: ALU ctrl code plus whether the ALU result is used or the op is a LOAD.
module acc_op_decode
  import acc_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  logic [2:0]        op,
  output logic [CTRL_W-1:0] ctrl,
  output logic              uses_alu,
  output logic              is_load
);

  // LOAD and NOP park the ALU on the AND code; its result is never written back for them.
  always_comb begin
    ctrl     = '0;
    uses_alu = 1'b1;
    is_load  = 1'b0;
    case (op)
      OP_AND:  ctrl = CTRL_W'(CTRL_AND);
      OP_OR:   ctrl = CTRL_W'(CTRL_OR);
      OP_ADD:  ctrl = CTRL_W'(CTRL_ADD);
      OP_SUB:  ctrl = CTRL_W'(CTRL_SUB);
      OP_SLT:  ctrl = CTRL_W'(CTRL_SLT);
      OP_NOR:  ctrl = CTRL_W'(CTRL_NOR);
      OP_LOAD: begin
        uses_alu = 1'b0;
        is_load  = 1'b1;
      end
      default: uses_alu = 1'b0;
    endcase
  end

endmodule

// File: rtl/acc_sequencer.sv
// Accumulator control stage feeding an external ALU; one instruction per IDLE->EXEC->DONE pass.
// Define ACC_STICKY_OVR_EN to make ovr_flag sticky until rst or LOAD.
module acc_sequencer
  import acc_pkg::*;
#(
  parameter int W      = 4,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [W-1:0]      in_operand,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_ovr,
  input  logic              alu_zero,
  output logic [W-1:0]      acc,
  output logic              ovr_flag,
  output logic              zero_flag,
  output logic              done
);

  state_t      state;
  logic [2:0]  op_q;
  logic [W-1:0] operand_q;
  logic        uses_alu;
  logic        is_load;
  logic        next_ovr;

  acc_op_decode #(
    .CTRL_W(CTRL_W)
  ) u_decode (
    .op      (op_q),
    .ctrl    (alu_ctrl),
    .uses_alu(uses_alu),
    .is_load (is_load)
  );

  assign alu_a = acc;
  assign alu_b = operand_q;

`ifdef ACC_STICKY_OVR_EN
  assign next_ovr = ovr_flag | alu_ovr;
`else
  assign next_ovr = alu_ovr;
`endif

  // Operands are captured only at the accept edge, so later input changes cannot reach the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      operand_q <= '0;
      acc       <= '0;
      ovr_flag  <= 1'b0;
      zero_flag <= 1'b1;
      done      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (in_valid && in_ready) begin
            op_q      <= in_op;
            operand_q <= in_operand;
            in_ready  <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (uses_alu) begin
            acc       <= alu_result;
            ovr_flag  <= next_ovr;
            zero_flag <= alu_zero;
          end else if (is_load) begin
            acc       <= operand_q;
            ovr_flag  <= 1'b0;
            zero_flag <= (operand_q == '0);
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
